// File: rtl/solo_squash_seq_ctrl.sv
// solo_squash_seq_ctrl
//   Run-control sequencer for the solo_squash game core, configured over a
//   Wishbone slave. Holds the game in reset while the project is deselected
//   (OFF), keeps reset asserted for a programmable number of cycles after
//   selection or a reset request (HOLD), then releases the game (RUN).
//
//   Ports
//     wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//     wbs_stb_i/cyc_i/we_i      Wishbone strobe, cycle, write enable
//     wbs_sel_i, wbs_dat_i      byte lanes, write data
//     wbs_adr_i                 address (block at BASE_ADDR, reg = adr[3:2])
//     wbs_ack_o, wbs_dat_o      acknowledge, read data (0 when not acking)
//     active                    project-selected flag
//     ext_reset_n               external reset request, active-low
//     vsync                     game vertical sync
//     game_reset                game core reset, active-high
//     out_enable                game pads may drive
//     sw_pause_n, sw_new_game_n software button requests, active-low
//
//   Registers: 0x0 CTRL (sw_reset pulse, pause, new_game pulse),
//              0x4 HOLD, 0x8 STATUS, 0xC FRAMES.
//   Build option: define FRAME_COUNTER_EN to count vsync rising edges in RUN
//   into FRAMES; otherwise FRAMES reads 0 and writes are ignored.
module solo_squash_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [15:0] HOLD_RESET = 16'd16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        active,
  input  logic        ext_reset_n,
  input  logic        vsync,
  output logic        game_reset,
  output logic        out_enable,
  output logic        sw_pause_n,
  output logic        sw_new_game_n
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        pause_q, pause_d;
  logic        new_game_q, new_game_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] frames_rd;

  logic        req, wr, ctrl_wr, sw_reset;
  logic [1:0]  reg_sel;
  logic [15:0] reload;

  // A new request is only taken while no ack is outstanding, so each
  // transfer is acknowledged exactly once.
  assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign wr       = req & wbs_we_i;
  assign reg_sel  = wbs_adr_i[3:2];
  assign ctrl_wr  = wr & (reg_sel == 2'd0) & wbs_sel_i[0];
  assign sw_reset = ctrl_wr & wbs_dat_i[0];
  // A programmed hold of 0 still spends one cycle in HOLD.
  assign reload   = (hold_q == '0) ? 16'd1 : hold_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!active) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_HOLD;
          cnt_d   = reload;
        end
        ST_HOLD: begin
          if (!ext_reset_n)     cnt_d   = reload;
          else if (cnt_q <= 16'd1) state_d = ST_RUN;
          else                  cnt_d   = cnt_q - 16'd1;
        end
        ST_RUN: begin
          if (sw_reset || !ext_reset_n) begin
            state_d = ST_HOLD;
            cnt_d   = reload;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    hold_d     = hold_q;
    pause_d    = pause_q;
    new_game_d = ctrl_wr & wbs_dat_i[2];
    if (ctrl_wr) pause_d = wbs_dat_i[1];
    if (wr && reg_sel == 2'd1) begin
      if (wbs_sel_i[0]) hold_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) hold_d[15:8] = wbs_dat_i[15:8];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (!wbs_we_i) begin
      case (reg_sel)
        2'd0:    rdata_d = {29'd0, 1'b0, pause_q, 1'b0};
        2'd1:    rdata_d = {16'd0, hold_q};
        2'd2:    rdata_d = {28'd0, ext_reset_n, active, state_q};
        default: rdata_d = frames_rd;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      hold_q     <= HOLD_RESET;
      pause_q    <= 1'b0;
      new_game_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      pause_q    <= pause_d;
      new_game_q <= new_game_d;
      ack_q      <= req;
      if (req) rdata_q <= rdata_d;
    end
  end

`ifdef FRAME_COUNTER_EN
  logic        vsync_q;
  logic [31:0] frames_q, frames_d;

  // A clearing write wins over a simultaneous vsync edge.
  always_comb begin
    frames_d = frames_q;
    if (wr && reg_sel == 2'd3)
      frames_d = '0;
    else if (state_q == ST_RUN && vsync && !vsync_q)
      frames_d = frames_q + 32'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      vsync_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      vsync_q  <= vsync;
      frames_q <= frames_d;
    end
  end

  assign frames_rd = frames_q;
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};
`else
  assign frames_rd = '0;
  logic unused_bits;
  assign unused_bits = ^{vsync, wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};
`endif

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = ack_q ? rdata_q : '0;
  assign game_reset    = (state_q != ST_RUN);
  assign out_enable    = (state_q == ST_RUN);
  assign sw_pause_n    = ~((state_q == ST_RUN) & pause_q);
  assign sw_new_game_n = ~((state_q == ST_RUN) & new_game_q);

endmodule

// File: tb/tb_solo_squash_seq_ctrl.sv
// Testbench for solo_squash_seq_ctrl: directed Wishbone/control stimulus,
// a timeline-based reference model checked every cycle, and literal
// expectations for the key sequencing scenarios.
module tb_solo_squash_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0, adr = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        active = 1'b0, ext_reset_n = 1'b1, vsync = 1'b0;
  logic        game_reset, out_enable, sw_pause_n, sw_new_game_n;

  solo_squash_seq_ctrl #(.BASE_ADDR(BASE), .HOLD_RESET(16'd16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .active(active), .ext_reset_n(ext_reset_n), .vsync(vsync),
    .game_reset(game_reset), .out_enable(out_enable),
    .sw_pause_n(sw_pause_n), .sw_new_game_n(sw_new_game_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: game state derived from a timeline. While selected,
  // the game runs from cycle m_release onwards; every (re)load of the hold
  // pushes m_release to now + hold length.
  int          cyc_n = 0;
  bit          m_valid = 0, m_on = 0;
  int          m_release = 0;
  logic [15:0] m_hold = 16'd16;
  bit          m_pause = 0, m_ng = 0, m_ack = 0, m_vs_prev = 0;
  logic [31:0] m_rdata = '0, m_frames = '0;
  bit          mreq, mwr, msw;
  logic [1:0]  mrs;
  int          mn, ms;

  function automatic int m_state();
    if (!m_on) return 0;
    if (cyc_n < m_release) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] readval(input logic [1:0] rs, input int s);
    logic [1:0] s2;
    s2 = s[1:0];
    case (rs)
      2'd0: return {30'd0, m_pause, 1'b0};
      2'd1: return {16'd0, m_hold};
      2'd2: return {28'd0, ext_reset_n, active, s2};
`ifdef FRAME_COUNTER_EN
      default: return m_frames;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    ms    = m_state();
    mreq  = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
    mwr   = mreq && we;
    mrs   = adr[3:2];
    mn    = (m_hold == 16'd0) ? 1 : int'(m_hold);
    msw   = mwr && mrs == 2'd0 && sel[0] && dat[0];
    cyc_n = cyc_n + 1;
    if (rst) begin
      m_valid = 1; m_on = 0; m_hold = 16'd16; m_pause = 0; m_ng = 0;
      m_ack = 0; m_rdata = '0; m_frames = '0; m_vs_prev = 0;
    end else begin
      if (mreq) m_rdata = we ? 32'd0 : readval(mrs, ms);
      m_ack = mreq;
      if (mwr && mrs == 2'd3) m_frames = '0;
      else if (ms == 2 && vsync && !m_vs_prev) m_frames = m_frames + 1;
      m_vs_prev = vsync;
      m_ng = mwr && mrs == 2'd0 && sel[0] && dat[2];
      if (mwr && mrs == 2'd0 && sel[0]) m_pause = dat[1];
      if (mwr && mrs == 2'd1) begin
        if (sel[0]) m_hold[7:0]  = dat[7:0];
        if (sel[1]) m_hold[15:8] = dat[15:8];
      end
      if (!active) m_on = 0;
      else if (ms == 0) begin m_on = 1; m_release = cyc_n + mn; end
      else if ((ms == 1 && !ext_reset_n) || (ms == 2 && (msw || !ext_reset_n)))
        m_release = cyc_n + mn;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      ms = m_state();
      check("game_reset", {31'd0, game_reset}, {31'd0, ms != 2});
      check("out_enable", {31'd0, out_enable}, {31'd0, ms == 2});
      check("sw_pause_n", {31'd0, sw_pause_n}, {31'd0, !(ms == 2 && m_pause)});
      check("sw_new_game_n", {31'd0, sw_new_game_n}, {31'd0, !(ms == 2 && m_ng)});
      check("ack", {31'd0, wbs_ack_o}, {31'd0, m_ack});
      check("dat_o", wbs_dat_o, m_ack ? m_rdata : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output bit acked);
    stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = s;
    acked = 0; rd = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      if (wbs_ack_o) begin acked = 1; rd = wbs_dat_o; end
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wb_write(input logic [3:0] r, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; bit ak;
    wb_xfer(BASE + {26'd0, r, 2'b00}, 1'b1, d, s, rd, ak);
    check("write_ack", {31'd0, ak}, 32'd1);
  endtask

  task automatic wb_read(input logic [3:0] r, output logic [31:0] rd);
    bit ak;
    wb_xfer(BASE + {26'd0, r, 2'b00}, 1'b0, 32'd0, 4'hF, rd, ak);
    check("read_ack", {31'd0, ak}, 32'd1);
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (!out_enable && n < 200) begin n++; tick(); end
  endtask

  task automatic pulse_vsync(input int k);
    for (int i = 0; i < k; i++) begin
      vsync = 1; tick(); vsync = 0; tick();
    end
  endtask

  logic [31:0] rd;
  int          n;
  bit          ak;
  logic [31:0] exp_frames;

  initial begin
`ifdef FRAME_COUNTER_EN
    exp_frames = 32'd3;
`else
    exp_frames = 32'd0;
`endif
    repeat (3) tick();
    check("rst_game_reset", {31'd0, game_reset}, 32'd1);
    check("rst_out_enable", {31'd0, out_enable}, 32'd0);
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_pause_n", {31'd0, sw_pause_n}, 32'd1);
    check("rst_new_game_n", {31'd0, sw_new_game_n}, 32'd1);
    rst = 0;
    wb_read(4'd1, rd);  check("hold_reset_val", rd, 32'h10);
    wb_read(4'd2, rd);  check("status_off", rd, 32'h8);

    // selection -> 16 cycles of HOLD -> RUN
    active = 1; tick();
    count_hold(n);      check("hold_len_16", n, 16);
    wb_read(4'd2, rd);  check("status_run", rd, 32'hE);

    wb_write(4'd0, 32'h2, 4'h1);
    check("pause_n_low", {31'd0, sw_pause_n}, 32'd0);

    // software reset re-enters HOLD for the programmed length
    wb_write(4'd0, 32'h1, 4'h1);
    check("swrst_game_reset", {31'd0, game_reset}, 32'd1);
    count_hold(n);      check("swrst_hold_len", n, 16);
    wb_read(4'd0, rd);  check("ctrl_bit0_clear", rd & 32'h1, 32'd0);

    wb_write(4'd0, 32'h4, 4'h1);
    check("new_game_low", {31'd0, sw_new_game_n}, 32'd0);
    tick();
    check("new_game_release", {31'd0, sw_new_game_n}, 32'd1);

    // HOLD of 0 behaves as a single cycle
    wb_write(4'd1, 32'h0, 4'hF);
    active = 0; tick(); active = 1; tick();
    count_hold(n);      check("hold_zero_len", n, 1);

    // HOLD write while holding only affects the next reload
    wb_write(4'd1, 32'h5, 4'hF);
    active = 0; tick(); active = 1; tick();
    wb_write(4'd1, 32'h3, 4'h3);
    count_hold(n);      check("hold_write_in_hold", n, 4);
    wb_read(4'd1, rd);  check("hold_readback", rd, 32'h3);

    // external reset held low keeps HOLD reloading
    ext_reset_n = 0; repeat (5) tick(); ext_reset_n = 1;
    count_hold(n);      check("ext_release_len", n, 3);

    // frame counting only in RUN; writes clear
    pulse_vsync(3);
    wb_read(4'd3, rd);  check("frames_run", rd, exp_frames);
    wb_write(4'd3, 32'h1234, 4'hF);
    wb_read(4'd3, rd);  check("frames_cleared", rd, 32'd0);
    ext_reset_n = 0; pulse_vsync(3); ext_reset_n = 1;
    count_hold(n);      check("ext_hold_len", n, 3);
    wb_read(4'd3, rd);  check("frames_hold", rd, 32'd0);

    // deselect wins over external reset
    ext_reset_n = 0; active = 0; tick();
    check("off_out_enable", {31'd0, out_enable}, 32'd0);
    check("off_game_reset", {31'd0, game_reset}, 32'd1);
    ext_reset_n = 1;

    // unmapped address never acknowledged
    wb_xfer(BASE + 32'h10, 1'b0, 32'd0, 4'hF, rd, ak);
    check("unmapped_no_ack", {31'd0, ak}, 32'd0);
    wb_read(4'd2, rd);  check("status_off2", rd, 32'h8);

    // reset during a request: no ack, no register effect
    stb = 1; cyc = 1; we = 1; adr = BASE + 32'h4; dat = 32'h55; sel = 4'hF; rst = 1;
    tick();
    check("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
    stb = 0; cyc = 0; we = 0; rst = 0;
    wb_read(4'd1, rd);  check("rst_mid_hold", rd, 32'h10);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
